// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, the BTB entry
// layout for the default geometry, and saturating counter arithmetic.
package bp_pkg;

  localparam int BP_ADDR_W  = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_CTR_W   = 2;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_ADDR_W - BP_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_CTR_W-1:0]  ctr;
  } btb_entry_t;

  // Counter helpers work on a 32-bit carrier; callers truncate to their width.
  function automatic logic [31:0] ctr_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] CTR_WEAK_T(input int w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] CTR_WEAK_NT(input int w);
    return CTR_WEAK_T(w) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return (v == ctr_max(w)) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? v : v - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for one saturating prediction counter.
// Priority: force_max, then load, then increment/decrement.
module sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] cur,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 force_max,
  input  logic                 load_en,
  input  logic [CTR_WIDTH-1:0] load_val,
  output logic [CTR_WIDTH-1:0] value
);

  always_comb begin
    value = cur;
    if (force_max) begin
      value = CTR_WIDTH'(ctr_max(CTR_WIDTH));
    end else if (load_en) begin
      value = load_val;
    end else if (inc) begin
      value = CTR_WIDTH'(sat_inc(32'(cur), CTR_WIDTH));
    end else if (dec) begin
      value = CTR_WIDTH'(sat_dec(32'(cur)));
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, looked up from fetch and
// trained from execute. Define BP_STATS_EN to build the hit/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] pc_f,
  output logic                  pred_taken_f,
  output logic [ADDR_WIDTH-1:0] pred_pc_f,
  input  logic                  upd_valid_e,
  input  logic                  upd_is_jump_e,
  input  logic [ADDR_WIDTH-1:0] upd_pc_e,
  input  logic                  upd_taken_e,
  input  logic [ADDR_WIDTH-1:0] upd_target_e,
  input  logic                  pred_taken_e,
  input  logic [ADDR_WIDTH-1:0] pred_pc_e,
  output logic                  mispredict_e,
  output logic [ADDR_WIDTH-1:0] redirect_pc_e,
  output logic [31:0]           hit_count,
  output logic [31:0]           mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [CTR_WIDTH-1:0] WEAK_T  = CTR_WIDTH'(CTR_WEAK_T(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(CTR_WEAK_NT(CTR_WIDTH));

  logic                  valid_q  [ENTRIES];
  logic                  valid_d  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr_q    [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr_d    [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_u;
  logic [TAG_W-1:0] tag_f, tag_u;
  logic             hit_f, hit_u, taken_u;
  logic [CTR_WIDTH-1:0]  ctr_upd;
  logic [ADDR_WIDTH-1:0] actual_next;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[ADDR_WIDTH-1:IDX_W+2];
  assign idx_u = upd_pc_e[IDX_W+1:2];
  assign tag_u = upd_pc_e[ADDR_WIDTH-1:IDX_W+2];

  // Reset masks the lookup so fetch sees a cold predictor during reset itself.
  assign hit_f        = !rst && valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f = hit_f && ctr_q[idx_f][CTR_WIDTH-1];
  assign pred_pc_f    = pred_taken_f ? target_q[idx_f] : pc_f + ADDR_WIDTH'(4);

  assign actual_next   = upd_taken_e ? upd_target_e : upd_pc_e + ADDR_WIDTH'(4);
  assign mispredict_e  = upd_valid_e && (actual_next != pred_pc_e);
  assign redirect_pc_e = upd_valid_e ? actual_next : '0;

  assign hit_u   = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
  assign taken_u = upd_taken_e || upd_is_jump_e;

  sat_counter #(.CTR_WIDTH(CTR_WIDTH)) u_ctr (
    .cur       (ctr_q[idx_u]),
    .inc       (hit_u && taken_u),
    .dec       (hit_u && !taken_u),
    .force_max (upd_is_jump_e),
    .load_en   (!hit_u),
    .load_val  (WEAK_T),
    .value     (ctr_upd)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid_e) begin
      if (hit_u) begin
        ctr_d[idx_u] = ctr_upd;
        if (taken_u) target_d[idx_u] = upd_target_e;
      end else if (taken_u) begin
        valid_d[idx_u]  = 1'b1;
        tag_d[idx_u]    = tag_u;
        target_d[idx_u] = upd_target_e;
        ctr_d[idx_u]    = ctr_upd;
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[gi]  <= 1'b0;
        tag_q[gi]    <= '0;
        target_q[gi] <= '0;
        ctr_q[gi]    <= WEAK_NT;
      end else begin
        valid_q[gi]  <= valid_d[gi];
        tag_q[gi]    <= tag_d[gi];
        target_q[gi] <= target_d[gi];
        ctr_q[gi]    <= ctr_d[gi];
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    hit_count_d        = hit_count_q + 32'(fetch_en && hit_f);
    mispredict_count_d = mispredict_count_q + 32'(mispredict_e);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q        <= '0;
      mispredict_count_q <= '0;
    end else begin
      hit_count_q        <= hit_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign hit_count        = hit_count_q;
  assign mispredict_count = mispredict_count_q;

  logic unused_ok;
  assign unused_ok = pred_taken_e;
`else
  assign hit_count        = '0;
  assign mispredict_count = '0;

  logic unused_ok;
  assign unused_ok = ^{pred_taken_e, fetch_en};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic compared against a field-level BTB model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        upd_valid_e, upd_is_jump_e, upd_taken_e, pred_taken_e;
  logic [31:0] upd_pc_e, upd_target_e, pred_pc_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e, hit_count, mispredict_count;

  int tests = 0;
  int fails = 0;

  // Reference model: one record per BTB slot, counter kept as a plain integer 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_hits;
  int unsigned m_miss;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_pc_f(pred_pc_f),
    .upd_valid_e(upd_valid_e), .upd_is_jump_e(upd_is_jump_e),
    .upd_pc_e(upd_pc_e), .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
    .pred_taken_e(pred_taken_e), .pred_pc_e(pred_pc_e),
    .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e),
    .hit_count(hit_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == (pc >> 6));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_hits = 0; m_miss = 0;
  endtask

  task automatic m_train(input logic [31:0] pc, input bit jmp, input bit tk, input logic [31:0] tgt);
    int  s;
    bit  t;
    s = slot(pc);
    t = tk || jmp;
    if (m_hit(pc)) begin
      if (jmp)    m_ctr[s] = 3;
      else if (t) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
      else        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      if (t) m_tgt[s] = tgt;
    end else if (t) begin
      m_valid[s] = 1'b1;
      m_tag[s]   = pc >> 6;
      m_tgt[s]   = tgt;
      m_ctr[s]   = jmp ? 3 : 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check combinational outputs, clock, check statistics.
  task automatic cyc(input bit r, input bit fen, input logic [31:0] pc,
                     input bit uv, input bit uj, input logic [31:0] upc,
                     input bit ut, input logic [31:0] utgt, input logic [31:0] ppe);
    logic [31:0] act;
    bit          mis;
    @(negedge clk);
    rst = r; fetch_en = fen; pc_f = pc;
    upd_valid_e = uv; upd_is_jump_e = uj; upd_pc_e = upc; upd_taken_e = ut;
    upd_target_e = utgt; pred_pc_e = ppe; pred_taken_e = (ppe != upc + 32'd4);
    #1;
    act = ut ? utgt : upc + 32'd4;
    mis = uv && (act != ppe);
    chk("pred_taken_f", 32'(pred_taken_f), r ? 32'd0 : 32'(m_taken(pc)));
    chk("pred_pc_f", pred_pc_f, r ? pc + 32'd4 : m_pred(pc));
    chk("mispredict_e", 32'(mispredict_e), 32'(mis));
    chk("redirect_pc_e", redirect_pc_e, uv ? act : 32'd0);
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      if (fen && m_hit(pc)) m_hits++;
      if (mis) m_miss++;
      if (uv) m_train(upc, uj, ut, utgt);
    end
    #1;
`ifdef BP_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("mispredict_count", mispredict_count, m_miss);
`else
    chk("hit_count", hit_count, 32'd0);
    chk("mispredict_count", mispredict_count, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] a, b, t;
    bit          uv, uj, ut;
    m_reset();
    rst = 1'b1; fetch_en = 1'b0; pc_f = '0;
    upd_valid_e = 1'b0; upd_is_jump_e = 1'b0; upd_pc_e = '0; upd_taken_e = 1'b0;
    upd_target_e = '0; pred_taken_e = 1'b0; pred_pc_e = '0;

    // Reset, then a cold lookup.
    cyc(1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("cold_pc", pred_pc_f, 32'h104);
    // Allocate 0x100 -> 0x80 (mispredicted, predicted fall-through).
    cyc(0, 1, 32'h000, 1, 0, 32'h100, 1, 32'h80, 32'h104);
    cyc(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    // Two not-taken updates, then a third that must saturate at zero.
    cyc(0, 1, 32'h100, 1, 0, 32'h100, 0, 0, 32'h80);
    cyc(0, 1, 32'h100, 1, 0, 32'h100, 0, 0, 32'h80);
    cyc(0, 1, 32'h100, 1, 0, 32'h100, 0, 0, 32'h104);
    cyc(0, 1, 32'h100, 1, 0, 32'h100, 1, 32'h80, 32'h104);
    cyc(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    // Alias 0x140 onto the same slot.
    cyc(0, 1, 32'h140, 1, 0, 32'h140, 1, 32'h400, 32'h144);
    cyc(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h140, 0, 0, 0, 0, 0, 0);
    chk("alias_pc", pred_pc_f, 32'h400);
    // Explicit mispredict / correct prediction.
    cyc(0, 0, 32'h200, 1, 0, 32'h200, 0, 0, 32'h300);
    cyc(0, 0, 32'h200, 1, 0, 32'h200, 0, 0, 32'h204);
    // Same-cycle update and lookup on 0x100, then the new entry.
    cyc(0, 1, 32'h100, 1, 0, 32'h100, 1, 32'h180, 32'h104);
    cyc(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("raw_new_pc", pred_pc_f, 32'h180);
    // Jump forces strong-taken; reset with a pending update discards it.
    cyc(0, 1, 32'h300, 1, 1, 32'h300, 1, 32'h40, 32'h304);
    cyc(0, 1, 32'h300, 1, 0, 32'h300, 0, 0, 32'h40);
    cyc(0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h300, 1, 0, 32'h500, 1, 32'h20, 32'h504);
    cyc(0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    // Wrap-around of pc+4 at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 0, 32'h0);

    // Randomized traffic over a small pool of colliding PCs.
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      b  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      t  = $urandom & 32'hFFFF_FFFC;
      uv = ($urandom_range(0, 3) != 0);
      uj = ($urandom_range(0, 5) == 0);
      ut = uj || ($urandom_range(0, 1) == 1);
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1), a, uv, uj, b, ut, t,
          ($urandom_range(0, 2) != 0) ? m_pred(b) : $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
